// File: rtl/load_store_unit_pkg.sv
// Shared codes for the load/store unit: load types, store masks, response
// error codes and the access FSM state type.
package load_store_unit_pkg;

  localparam logic [2:0] LT_NONE = 3'd0;
  localparam logic [2:0] LT_LB   = 3'd1;
  localparam logic [2:0] LT_LH   = 3'd2;
  localparam logic [2:0] LT_LW   = 3'd3;
  localparam logic [2:0] LT_LBU  = 3'd5;
  localparam logic [2:0] LT_LHU  = 3'd6;

  localparam logic [3:0] SB_MASK = 4'b0001;
  localparam logic [3:0] SH_MASK = 4'b0011;
  localparam logic [3:0] SW_MASK = 4'b1111;

  localparam logic [1:0] LSU_OK       = 2'd0;
  localparam logic [1:0] LSU_MISALIGN = 2'd1;
  localparam logic [1:0] LSU_TIMEOUT  = 2'd2;
  localparam logic [1:0] LSU_ILLEGAL  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends
// it according to the load type.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{offset_i, 3'b000} +: 8];
    half_v = word_i[{offset_i[1], 4'b0000} +: 16];
    case (load_type_i)
      LT_LB:   data_o = {{24{byte_v[7]}}, byte_v};
      LT_LBU:  data_o = {24'd0, byte_v};
      LT_LH:   data_o = {{16{half_v[15]}}, half_v};
      LT_LHU:  data_o = {16'd0, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access unit: classifies an EX request, drives one registered
// req/gnt/rvalid bus transaction and returns a single-cycle response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  mem_write,
  input  logic [2:0]  load_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [3:0]       bus_be_q, bus_be_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [2:0]       lt_q, lt_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       err_q, err_d;

  logic        is_store, mask_ok, lt_ok, illegal, is_half, is_word, misalign;
  logic        timeout_hit;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [31:0] load_data;

  // Request classification, evaluated on the raw EX inputs.
  always_comb begin
    is_store = |mem_write;
    mask_ok  = mem_write inside {4'b0000, SB_MASK, SH_MASK, SW_MASK};
    lt_ok    = !(load_type inside {3'd4, 3'd7});
    illegal  = !mask_ok || !lt_ok || (is_store && (load_type != LT_NONE)) ||
               (!is_store && (load_type == LT_NONE));
    is_half  = (mem_write == SH_MASK) || (load_type inside {LT_LH, LT_LHU});
    is_word  = (mem_write == SW_MASK) || (load_type == LT_LW);
    misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    store_be = mem_write << addr[1:0];
    case (mem_write)
      SB_MASK: store_wdata = {4{wdata[7:0]}};
      SH_MASK: store_wdata = {2{wdata[15:0]}};
      default: store_wdata = wdata;
    endcase
  end

  assign timeout_hit = (cnt_q == CNT_LIM);

  load_align u_align (
    .word_i      (bus_rdata),
    .offset_i    (off_q),
    .load_type_i (lt_q),
    .data_o      (load_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    lt_d        = lt_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cnt_d = '0;
          if (illegal) begin
            state_d = S_RESP;
            err_d   = LSU_ILLEGAL;
            rdata_d = '0;
          end else if (misalign) begin
            state_d = S_RESP;
            err_d   = LSU_MISALIGN;
            rdata_d = '0;
          end else begin
            state_d     = S_ADDR;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_we_d    = is_store;
            bus_be_d    = is_store ? store_be : 4'b1111;
            bus_wdata_d = store_wdata;
            lt_d        = load_type;
            off_d       = addr[1:0];
          end
        end
      end
      S_ADDR: begin
        // Counter saturates at the limit; a grant in the limit cycle still wins.
        cnt_d = timeout_hit ? cnt_q : cnt_q + 1'b1;
        if (bus_gnt) begin
          state_d = S_DATA;
        end else if (timeout_hit) begin
          state_d = S_RESP;
          err_d   = LSU_TIMEOUT;
          rdata_d = '0;
        end
      end
      S_DATA: begin
        cnt_d = timeout_hit ? cnt_q : cnt_q + 1'b1;
        if (bus_rvalid) begin
          state_d = S_RESP;
          err_d   = LSU_OK;
          rdata_d = bus_we_q ? 32'd0 : load_data;
        end else if (timeout_hit) begin
          state_d = S_RESP;
          err_d   = LSU_TIMEOUT;
          rdata_d = '0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      lt_q        <= LT_NONE;
      off_q       <= '0;
      rdata_q     <= '0;
      err_q       <= LSU_OK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      lt_q        <= lt_d;
      off_q       <= off_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign bus_req    = (state_q == S_ADDR);
  assign resp_valid = (state_q == S_RESP);
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases with literal expectations plus
// randomized transactions scored against a transaction-level model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  mem_write = '0;
  logic [2:0]  load_type = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_write(mem_write), .load_type(load_type), .addr(addr), .wdata(wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    int          cyc;
    logic [1:0]  err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  int          req_lo = -1, req_hi = -2, busy_lo = -1, busy_hi = -2;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_be = '0;
  int          checks = 0, errors = 0;
  bit          chk_en = 1'b0;
  int          acc_cyc = 0, last_resp_cyc = -100, prev_resp_cyc = -100;
  logic [31:0] last_rdata = '0, cap_addr = '0, cap_wdata = '0;
  logic [1:0]  last_err = '0;
  logic [3:0]  cap_be = '0;
  logic        cap_we = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the expectations set up by the driver.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      bit er, eb, ev;
      er = (cyc >= req_lo) && (cyc <= req_hi);
      eb = (cyc >= busy_lo) && (cyc <= busy_hi);
      ev = (q.size() > 0) && (q[0].cyc == cyc);
      chk("bus_req", 32'(bus_req), 32'(er));
      if (bus_req && er) begin
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_we", 32'(bus_we), 32'(exp_we));
        chk("bus_be", 32'(bus_be), 32'(exp_be));
        if (exp_we) chk("bus_wdata", bus_wdata, exp_wdata);
        cap_addr = bus_addr; cap_we = bus_we; cap_be = bus_be; cap_wdata = bus_wdata;
      end
      chk("req_ready", 32'(req_ready), 32'(!eb));
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      if (ev) begin
        if (resp_valid) begin
          chk("resp_err", 32'(resp_err), 32'(q[0].err));
          chk("resp_rdata", resp_rdata, q[0].rdata);
          last_err = resp_err;
          last_rdata = resp_rdata;
          prev_resp_cyc = last_resp_cyc;
          last_resp_cyc = cyc;
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (!req_ready && guard < 60);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL idle_wait at cycle %0d: got busy expected idle", cyc);
    end
  endtask

  // One request plus its bus responder; model computes the expected outcome.
  task automatic do_txn(input logic [3:0] mw, input logic [2:0] lt,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input logic [31:0] rdat, input int gd, input int rd,
                        input bit stray);
    int a, sz, g, r, lim, rc, guard, off;
    bit legal, store, mis;
    logic [1:0] err;
    logic [31:0] val, msk;
    exp_t e;
    guard = 0;
    while (!req_ready) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 60) begin
        checks++; errors++;
        $display("FAIL ready_wait at cycle %0d: got busy expected idle", cyc);
        return;
      end
    end
    store = (mw != 4'd0);
    legal = (!store && (lt inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6})) ||
            ((lt == 3'd0) && (mw inside {4'd1, 4'd3, 4'd15}));
    if (store) sz = $countones(mw);
    else if (lt == LT_LB || lt == LT_LBU) sz = 1;
    else if (lt == LT_LH || lt == LT_LHU) sz = 2;
    else sz = 4;
    off = int'(ad[1:0]);
    mis = legal && ((off % sz) != 0);
    a = cyc;
    acc_cyc = a;
    req_valid = 1'b1; mem_write = mw; load_type = lt; addr = ad; wdata = wd;
    if (!legal || mis) begin
      e.cyc = a + 1; e.err = legal ? 2'd1 : 2'd3; e.rdata = '0;
      req_lo = -1; req_hi = -2; busy_lo = a + 1; busy_hi = a + 1;
      q.push_back(e);
    end else begin
      exp_addr = ad & 32'hFFFF_FFFC;
      exp_we = store;
      exp_be = store ? 4'(mw << ad[1:0]) : 4'hF;
      if (sz == 1) exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
      else if (sz == 2) exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      else exp_wdata = wd;
      g = a + 1 + gd;
      if (gd > T - 1) begin
        rc = a + T + 1; req_hi = a + T; err = 2'd2;
      end else begin
        req_hi = g;
        r = g + 1 + rd;
        lim = (a + T > g + 1) ? a + T : g + 1;
        if (r <= lim) begin rc = r + 1; err = 2'd0; end
        else begin rc = lim + 1; err = 2'd2; end
      end
      req_lo = a + 1; busy_lo = a + 1; busy_hi = rc;
      val = '0;
      if (err == 2'd0 && !store) begin
        msk = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        val = (rdat >> (8 * off)) & msk;
        if ((lt == LT_LB || lt == LT_LH) && val[8 * sz - 1]) val = val | ~msk;
      end
      e.cyc = rc; e.err = err; e.rdata = val;
      q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_write = 4'($urandom); load_type = 3'($urandom);
    addr = $urandom; wdata = $urandom;
    if (legal && !mis) begin
      repeat (gd) begin
        bus_rvalid = stray; bus_rdata = $urandom;
        @(posedge clk); #1;
      end
      bus_rvalid = 1'b0; bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      repeat (rd) begin
        bus_gnt = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rdat;
      @(posedge clk); #1;
      bus_rvalid = 1'b0; bus_rdata = $urandom;
    end
  endtask

  logic [2:0] lts [5] = '{LT_LB, LT_LH, LT_LW, LT_LBU, LT_LHU};
  logic [3:0] sms [3] = '{SB_MASK, SH_MASK, SW_MASK};

  initial begin
    int a, sel;
    logic [3:0] mw;
    logic [2:0] lt;
    logic [31:0] ad;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    do_txn(4'd0, LT_LB, 32'h103, 32'd0, 32'h80FF_1234, 0, 0, 1'b0);
    wait_idle();
    chk("lb_latency", 32'(last_resp_cyc - acc_cyc), 32'd3);
    chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
    chk("lb_err", 32'(last_err), 32'd0);
    do_txn(4'd0, LT_LBU, 32'h103, 32'd0, 32'h80FF_1234, 0, 0, 1'b0);
    wait_idle();
    chk("lbu_rdata", last_rdata, 32'h0000_0080);

    do_txn(SH_MASK, LT_NONE, 32'h202, 32'h0000_ABCD, 32'd0, 0, 1, 1'b0);
    wait_idle();
    chk("sh_be", 32'(cap_be), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(cap_we), 32'd1);
    chk("sh_addr", cap_addr, 32'h200);
    chk("sh_err", 32'(last_err), 32'd0);

    do_txn(4'd0, LT_LW, 32'h101, 32'd0, 32'd0, 0, 0, 1'b0);
    wait_idle();
    chk("mis_err", 32'(last_err), 32'd1);
    chk("mis_latency", 32'(last_resp_cyc - acc_cyc), 32'd1);
    do_txn(4'b0101, LT_NONE, 32'h100, 32'd0, 32'd0, 0, 0, 1'b0);
    wait_idle();
    chk("ill_err", 32'(last_err), 32'd3);

    do_txn(4'd0, LT_LW, 32'h500, 32'd0, 32'h1111_2222, 10, 0, 1'b0);
    wait_idle();
    chk("to_err", 32'(last_err), 32'd2);
    chk("to_latency", 32'(last_resp_cyc - acc_cyc), 32'd5);
    do_txn(4'd0, LT_LW, 32'h500, 32'd0, 32'h3333_4444, 3, 0, 1'b0);
    wait_idle();
    chk("lastgnt_err", 32'(last_err), 32'd0);
    chk("lastgnt_rdata", last_rdata, 32'h3333_4444);

    // Reset while the access sits in DATA, then a late completion.
    a = cyc;
    req_valid = 1'b1; mem_write = 4'd0; load_type = LT_LW; addr = 32'h300;
    exp_addr = 32'h300; exp_we = 1'b0; exp_be = 4'hF;
    req_lo = a + 1; req_hi = a + 1; busy_lo = a + 1; busy_hi = a + 1000;
    @(posedge clk); #1;
    req_valid = 1'b0; bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_bus_req", 32'(bus_req), 32'd0);
    chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstmid_req_ready", 32'(req_ready), 32'd1);
    req_hi = -2; busy_hi = -2;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_0000;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_txn(4'd0, LT_LW, 32'h304, 32'd0, 32'h1234_5678, 1, 1, 1'b0);
    wait_idle();
    chk("postrst_rdata", last_rdata, 32'h1234_5678);

    do_txn(SW_MASK, LT_NONE, 32'h400, 32'hDEAD_BEEF, 32'd0, 2, 0, 1'b1);
    do_txn(4'd0, LT_LW, 32'h404, 32'd0, 32'hCAFE_F00D, 0, 0, 1'b0);
    wait_idle();
    chk("b2b_accept", 32'(acc_cyc), 32'(prev_resp_cyc + 1));
    chk("b2b_rdata", last_rdata, 32'hCAFE_F00D);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 45) begin
        mw = 4'd0; lt = lts[$urandom_range(0, 4)];
      end else if (sel < 80) begin
        lt = LT_NONE; mw = sms[$urandom_range(0, 2)];
      end else begin
        mw = 4'($urandom); lt = 3'($urandom);
      end
      ad = $urandom;
      if ($urandom_range(0, 1) == 1) ad[1:0] = 2'b00;
      do_txn(mw, lt, ad, $urandom, $urandom, $urandom_range(0, 4),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Executes one data-memory access per request, driven by decode's load-type and store byte-mask control signals: shifts the store mask and data onto a 32-bit word bus, and extracts and extends the load data. Sits between the EX/MEM pipeline register and the data-memory bus. It runs a req/gnt/rvalid handshake and holds the pipeline through `req_ready` while an access is outstanding. Misaligned, illegal and timed-out accesses are reported in the response instead of being issued or hanging.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles allowed in ADDR+DATA before abort; must be ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: EX presents a memory op.
- `req_ready` out 1: high only in IDLE; accept = `req_valid && req_ready`.
- `mem_write` in 4: unshifted store mask: 0001 SB, 0011 SH, 1111 SW, 0000 not a store.
- `load_type` in 3: register-write encoding: 0 none, 1 LB, 2 LH, 3 LW, 5 LBU, 6 LHU.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32, `bus_be` out 4, `bus_wdata` out 32: registered bus command.
- `bus_gnt` in 1: command accepted.
- `bus_rvalid` in 1: completion; carries load data, or is the write acknowledge.
- `bus_rdata` in 32: read word.
- `resp_valid` out 1: one-cycle response strobe.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 2: 0 ok, 1 misaligned, 2 timeout, 3 illegal.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE, on accept, classify the request:
  - Illegal: `mem_write` not in {0000, 0001, 0011, 1111}; or nonzero `mem_write` with nonzero `load_type`; or both zero; or `load_type` ∈ {4, 7}. Go to RESP with err 3.
  - Misaligned: half access with `addr[0]`=1, or word access with `addr[1:0]`≠0. Go to RESP with err 1.
  - Otherwise go to ADDR and latch `bus_addr`={addr[31:2],2'b00}, `bus_we`=|mem_write, `bus_be`=store ? mask<<addr[1:0] : 4'b1111, and `bus_wdata` (byte replicated ×4, half ×2, word as-is). Latch `load_type` and `addr[1:0]`.
- ADDR: `bus_req`=1 with the command held stable. `bus_gnt` moves to DATA.
- DATA: `bus_req`=0. `bus_rvalid` moves to RESP with err 0.
- Load extraction from `bus_rdata` at the latched offset:
  - LB/LBU: byte at offset, sign- or zero-extended.
  - LH/LHU: half at offset, sign- or zero-extended.
  - LW: full word.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. There is no back-pressure on the response.
- Timeout counter:
  - Cleared on accept; increments every cycle in ADDR or DATA.
  - When it reaches TIMEOUT_CYCLES-1 with no gnt/rvalid that cycle: go to RESP with err 2, drop `bus_req`.
  - If `bus_gnt` or `bus_rvalid` arrives in that same cycle, it wins over the timeout.
- `bus_rvalid` outside DATA and `bus_gnt` outside ADDR are ignored.
- Reset, including mid-transaction, takes effect immediately: state IDLE, `bus_req`=0, outstanding transaction abandoned.

## Timing
- Reset values:
  - `req_ready`=1.
  - `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- All outputs are registered or decoded from state.
- Accept at cycle 0 → `bus_req` high at cycle 1.
- `bus_gnt` at cycle g → `bus_req` low at g+1.
- `bus_rvalid` at cycle r → `resp_valid` at r+1.
- Minimum accept-to-response latency: 3 cycles (gnt at 1, rvalid at 2, resp at 3).
- Error path: accept at 0 → `resp_valid` at 1, no bus activity.
- `req_ready` is high in IDLE only, so the next accept is possible in the cycle after RESP.
- `resp_rdata` and `resp_err` are valid only while `resp_valid`=1, and are held until the next response.

## Structure
- Shared constants are added to `Parameters.v` as `` `define `` entries:
  - load-type codes LB, LH, LW, LBU, LHU (`NOREGWRITE` and `LW` already exist);
  - store masks SB_MASK, SH_MASK, SW_MASK;
  - LSU_OK, LSU_MISALIGN, LSU_TIMEOUT, LSU_ILLEGAL.
- FSM state encodings are local localparams.
- One combinational sub-module, `load_align`: inputs word, offset and load_type; output the extended 32-bit value.

## Test plan
- LB at addr 0x103, rdata 0x80FF_1234, gnt at 1, rvalid at 2 → `resp_valid` at cycle 3, rdata 0xFFFF_FF80, err 0. LBU on the same beat → 0x0000_0080.
- SH at addr 0x202, wdata 0x0000_ABCD → `bus_be`=1100, `bus_wdata`=0xABCD_ABCD, `bus_we`=1, `bus_addr`=0x200. Resp err 0 after rvalid.
- LW at 0x101 → no `bus_req`, `resp_valid` next cycle with err 1. `mem_write`=0101 → err 3.
- LW with `bus_gnt` never asserted, TIMEOUT_CYCLES=4 → `bus_req` drops and err 2 after 4 cycles. A second run with gnt on the final count cycle proceeds normally.
- `rst_n` pulsed low while in DATA → `bus_req`/`resp_valid` 0 immediately. A late `bus_rvalid` after reset produces no response. The next request completes normally.
- Back-to-back SW then LW → second accept occurs in the cycle after the first `resp_valid`. Stray `bus_rvalid` while in ADDR is ignored.
